// File: rtl/pipe_stage_buf.sv
// Pipeline stage boundary register with valid/ready handshake, synchronous flush
// and a two-entry skid buffer so in_ready never depends combinationally on out_ready.
module pipe_stage_buf #(
  parameter int CTRL_W       = 16,
  parameter int DATA_W       = 192,
  parameter int ZERO_INVALID = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              accept, drain;

  // Handshake outputs come only from the state register (and rst_n), which
  // breaks the ready path between neighbouring stages.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL) && rst_n;
  assign occupancy = state;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // NOTE: the entry registers are reset too; a bubble must never expose stale or X payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all sequential state uses <= so every register samples pre-edge values.
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end else if (accept) begin
            state     <= FULL;
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state     <= ONE;
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Stall counter keeps counting through a flush cycle and never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  generate
    if (ZERO_INVALID != 0) begin : g_mask
      assign out_ctrl = out_valid ? main_ctrl : '0;
      assign out_data = out_valid ? main_data : '0;
    end else begin : g_nomask
      assign out_ctrl = main_ctrl;
      assign out_data = main_data;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf: a default instance plus a
// CNT_W=4 / unmasked instance sharing the same stimulus.
module tb_pipe_stage_buf;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 192;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;

  logic              in_ready, out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [15:0]       stall_cnt;

  logic              s_in_ready, s_out_valid;
  logic [CTRL_W-1:0] s_out_ctrl;
  logic [DATA_W-1:0] s_out_data;
  logic [1:0]        s_occupancy;
  logic [3:0]        s_stall_cnt;

  int n_asserts = 0;
  int n_fail    = 0;

  pipe_stage_buf dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_buf #(.CNT_W(4), .ZERO_INVALID(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_data  = d;
    in_ctrl  = 16'hC000 | d[15:0];
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctrl", out_ctrl, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", in_ready, 1);

    // Streaming 1..8 with out_ready held high
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i);
      tick();
      check($sformatf("stream_data_%0d", i), out_data, i);
      check($sformatf("stream_ctrl_%0d", i), out_ctrl, 16'hC000 | i);
      check($sformatf("stream_occ_%0d", i), occupancy, 1);
      check($sformatf("stream_rdy_%0d", i), in_ready, 1);
    end
    drive(1'b0, '0);
    tick();
    check("stream_end_valid", out_valid, 0);
    check("stream_end_masked", out_data, 0);
    check("stream_end_unmasked", s_out_data, 8);
    check("stream_stall", stall_cnt, 0);

    // Back-pressure into the skid entry
    out_ready = 1'b0;
    drive(1'b1, 'hA);
    tick();
    check("bp_a_data", out_data, 'hA);
    check("bp_a_occ", occupancy, 1);
    drive(1'b1, 'hB);
    tick();
    check("bp_full_occ", occupancy, 2);
    check("bp_full_rdy", in_ready, 0);
    check("bp_full_data", out_data, 'hA);
    drive(1'b1, 'hC);
    tick();
    check("bp_hold_data", out_data, 'hA);
    check("bp_hold_occ", occupancy, 2);
    out_ready = 1'b1;
    tick();
    check("bp_b_data", out_data, 'hB);
    check("bp_b_occ", occupancy, 1);
    check("bp_b_rdy", in_ready, 1);
    tick();
    check("bp_c_data", out_data, 'hC);
    check("bp_c_occ", occupancy, 1);
    drive(1'b0, '0);
    tick();
    check("bp_empty_valid", out_valid, 0);
    check("bp_stall", stall_cnt, 2);

    // Flush while FULL and stalled
    out_ready = 1'b0;
    drive(1'b1, 'h11);
    tick();
    drive(1'b1, 'h22);
    tick();
    check("fl_full_occ", occupancy, 2);
    drive(1'b1, 'h33);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_ctrl", out_ctrl, 0);
    check("fl_data", out_data, 0);
    check("fl_occ", occupancy, 0);
    check("fl_rdy", in_ready, 1);
    check("fl_stall", stall_cnt, 4);
    drive(1'b0, '0);
    out_ready = 1'b1;
    tick();
    check("fl_no_33_valid", out_valid, 0);
    check("fl_no_33_held", s_out_data, 'h11);

    // Flush in ONE while an upstream handshake completes: entry discarded
    drive(1'b1, 'h44);
    out_ready = 1'b0;
    tick();
    drive(1'b1, 'h55);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0);
    check("fl1_valid", out_valid, 0);
    check("fl1_occ", occupancy, 0);
    check("fl1_stall", stall_cnt, 5);

    // Simultaneous accept and drain in ONE
    out_ready = 1'b1;
    drive(1'b1, 'h5);
    tick();
    check("ad_first", out_data, 'h5);
    drive(1'b1, 'h6);
    tick();
    check("ad_data", out_data, 'h6);
    check("ad_occ", occupancy, 1);
    drive(1'b0, '0);
    tick();

    // Asynchronous reset between edges while FULL
    out_ready = 1'b0;
    drive(1'b1, 'h40);
    tick();
    drive(1'b1, 'h41);
    tick();
    check("ar_full_occ", occupancy, 2);
    check("ar_stall_pre", stall_cnt, 6);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_rdy", in_ready, 0);
    check("ar_data", out_data, 0);
    check("ar_ctrl", out_ctrl, 0);
    check("ar_occ", occupancy, 0);
    check("ar_stall", stall_cnt, 0);
    check("ar_unmasked_zero", s_out_data, 0);
    drive(1'b0, '0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 'h7);
    #1;
    check("ar_rel_rdy", in_ready, 1);
    tick();
    check("ar_first_data", out_data, 'h7);
    check("ar_first_occ", occupancy, 1);

    // Stall counter saturation on the CNT_W=4 instance
    drive(1'b0, '0);
    out_ready = 1'b0;
    repeat (20) tick();
    check("sat_valid", s_out_valid, 1);
    check("sat_small", s_stall_cnt, 15);
    check("sat_wide", stall_cnt, 20);
    repeat (3) tick();
    check("sat_hold", s_stall_cnt, 15);
    check("sat_wide_more", stall_cnt, 23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
